// File: rtl/csa_accum_ctrl.sv
// Operand-stream accumulator: running total kept as sum/carry words through one
// carry-save adder, resolved by a single carry-propagate add after the last operand.

module carry_save_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    output logic [15:0] sum,
    output logic [15:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// state   | meaning
// IDLE    | waiting for start
// ACCUM   | accepting operands into S/C
// RESOLVE | one-cycle carry-propagate add S+C
// DONE    | result held until consumer handshake
module csa_accum_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] ops_left
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] s_q, s_nxt, c_q, c_nxt, res_q, res_nxt;
    logic [CNT_W-1:0] left_q, left_nxt;
    logic [WIDTH-1:0] csa_sum, csa_carry, carry_shl;

    carry_save_adder u_csa (
        .a     (s_q),
        .b     (c_q),
        .c     (in_data),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    // Carry bit i weighs 2^(i+1); the bit shifted out is dropped (mod 2^16).
    assign carry_shl = csa_carry << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s_q    <= '0;
            c_q    <= '0;
            res_q  <= '0;
            left_q <= '0;
        end else begin
            state  <= state_nxt;
            s_q    <= s_nxt;
            c_q    <= c_nxt;
            res_q  <= res_nxt;
            left_q <= left_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        c_nxt     = c_q;
        res_nxt   = res_q;
        left_nxt  = left_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        s_nxt     = '0;
                        c_nxt     = '0;
                        left_nxt  = count;
                        state_nxt = ACCUM;
                    end else begin
                        res_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_nxt    = csa_sum;
                    c_nxt    = carry_shl;
                    left_nxt = left_q - ONE;
                    if (left_q == ONE)
                        state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                res_nxt   = s_q + c_q;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign out_data = res_q;
    assign ops_left = left_q;
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed bench for csa_accum_ctrl: a behavioural job model checked every cycle,
// plus literal expected sums, latency and flow-control checks.

module tb_csa_accum_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, out_ready;
    logic [7:0]  count;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data;
    logic [7:0]  ops_left;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_acc = 0;
    bit chk_en = 1'b0;

    // model: phase 0 idle, 1 taking operands, 2 resolving, 3 result offered
    int m_ph = 0, m_left = 0, m_acc = 0, m_res = 0;

    csa_accum_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .ops_left(ops_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_ph = 0; m_left = 0; m_acc = 0; m_res = 0;
        end else begin
            case (m_ph)
                0: if (start) begin
                    if (count != 0) begin
                        m_ph = 1; m_left = count; m_acc = 0;
                    end else begin
                        m_ph = 3; m_res = 0;
                    end
                end
                1: if (in_valid) begin
                    m_acc = (m_acc + int'(in_data)) % 65536;
                    m_left = m_left - 1;
                    if (m_left == 0) m_ph = 2;
                end
                2: begin m_res = m_acc; m_ph = 3; end
                default: if (out_ready) m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy",      int'(busy),      int'(m_ph != 0));
            chk("m_in_ready",  int'(in_ready),  int'(m_ph == 1));
            chk("m_out_valid", int'(out_valid), int'(m_ph == 3));
            chk("m_ops_left",  int'(ops_left),  m_left);
            chk("m_out_data",  int'(out_data),  m_res);
        end
    end

    task automatic start_job(input int n);
        start = 1'b1;
        count = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int d, input int exp_left, input int gap);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_wait", int'(in_ready), 1);
        chk("ops_left_pre", int'(ops_left), exp_left);
        in_valid = 1'b1;
        in_data  = 16'(d);
        last_acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic get_result(input int exp, input int hold, input bit check_lat);
        int n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("out_valid_wait", int'(out_valid), 1);
        // out_valid rises at the edge right after the one taking the last operand
        if (check_lat) chk("latency_edges", cyc - last_acc, 1);
        chk("result", int'(out_data), exp);
        chk("ops_left_done", int'(ops_left), 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), exp);
            chk("hold_busy", int'(busy), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_ops_left", int'(ops_left), 0);
        rst = 1'b0;
        @(negedge clk);

        // basic back-to-back sum with latency check
        out_ready = 1'b1;
        start_job(3);
        out_ready = 1'b0;
        send(10, 3, 0); send(5, 2, 0); send(7, 1, 0);
        get_result(22, 0, 1'b1);

        // carry ripple and wraparound
        start_job(3);
        send(255, 3, 0); send(128, 2, 0); send(1, 1, 0);
        get_result(384, 0, 1'b1);
        start_job(2);
        send(65535, 2, 0); send(1, 1, 0);
        get_result(0, 0, 1'b1);
        start_job(3);
        send(12345, 3, 0); send(54321, 2, 0); send(11111, 1, 0);
        get_result(12241, 0, 1'b1);

        // zero count goes straight to a zero result; single operand
        start_job(0);
        chk("zero_in_ready", int'(in_ready), 0);
        get_result(0, 0, 1'b0);
        start_job(1);
        send(32767, 1, 0);
        get_result(32767, 0, 1'b1);

        // bubbles between operands and consumer back-pressure
        start_job(4);
        send(1000, 4, 2); send(1000, 3, 2); send(1000, 2, 2); send(1000, 1, 0);
        get_result(4000, 3, 1'b1);

        // start during accumulation is ignored
        start_job(2);
        send(3, 2, 0);
        start = 1'b1; count = 8'd9;
        send(4, 1, 0);
        start = 1'b0;
        get_result(7, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_second_job", int'(busy), 0);
        end

        // reset mid-accumulation discards the partial sum
        start_job(5);
        send(1, 5, 0); send(2, 4, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_ops_left", int'(ops_left), 0);
        @(negedge clk);
        start_job(2);
        send(100, 2, 0); send(200, 1, 0);
        get_result(300, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
